calc_arbiter: RTL and testbench

//  Shares one 4-bit calculator datapath (sub-module calc_alu) between two requesters.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_alu.sv | 44 ++++
 rtl/calc_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_calc_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the calculator arbiter slice:
//               3-bit calculator opcodes and the 2-bit arbiter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Calculator opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc_alu
// Description : Purely combinational 4-bit calculator datapath, 8-bit result.
// Ports       : a   [3:0] in  - operand a (unsigned)
//               b   [3:0] in  - operand b (unsigned)
//               op  [2:0] in  - opcode (calc_pkg::OP_*)
//               res [7:0] out - result
// Revision    : 1.0 - initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [7:0] res
);

    logic [7:0] w_a_ext;
    logic [7:0] w_b_ext;

    assign w_a_ext = {4'b0000, a};
    assign w_b_ext = {4'b0000, b};

    always_comb begin
        res = 8'h00;
        case (op)
            OP_ADD:  res = w_a_ext + w_b_ext;
            // 8-bit subtraction of zero-extended operands yields the
            // sign-extended two's complement difference directly.
            OP_SUB:  res = w_a_ext - w_b_ext;
            OP_MUL:  res = w_a_ext * w_b_ext;
            OP_AND:  res = w_a_ext & w_b_ext;
            OP_OR:   res = w_a_ext | w_b_ext;
            OP_XOR:  res = w_a_ext ^ w_b_ext;
            OP_SHL:  res = w_a_ext << b[1:0];
            OP_SHR:  res = w_a_ext >> b[1:0];
            default: res = 8'h00;
        endcase
    end

endmodule : calc_alu
`default_nettype wire

// File: rtl/calc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : calc_arbiter
// Description : Shares one calc_alu between two requesters. Round-robin
//               arbitration accepts one operation at a time (valid/ready),
//               holds the latched operands for a per-opcode latency and
//               returns the 8-bit result tagged with the requester id.
// Ports       : clk, rst (async, active-high)
//               req_valid[1:0] in, req_ready[1:0] out (combinational, one-hot/0)
//               req0_a/b, req1_a/b [3:0] in; req0_op/req1_op [2:0] in
//               resp_valid out, resp_ready in, resp_data[7:0] out, resp_id out
//               busy out (FSM not idle)
//               gnt_cnt0/gnt_cnt1 [CNT_W-1:0] out (CALC_ARB_STATS_EN only)
// Config      : define CALC_ARB_STATS_EN to add per-requester grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 3
`ifdef CALC_ARB_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_id,
    output logic       busy
`ifdef CALC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    // Latency counter sized for the longest op; it holds (cycles - 1).
    localparam int c_MAX_CYCLES = (ALU_CYCLES > MUL_CYCLES) ? ALU_CYCLES : MUL_CYCLES;
    localparam int c_CNT_BITS   = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam logic [c_CNT_BITS-1:0] c_ALU_LOAD = c_CNT_BITS'(ALU_CYCLES - 1);
    localparam logic [c_CNT_BITS-1:0] c_MUL_LOAD = c_CNT_BITS'(MUL_CYCLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [3:0]            r_a;
    logic [3:0]            r_b;
    logic [2:0]            r_op;
    logic                  r_id;
    logic                  r_last_gnt;
    logic                  r_resp_valid;
    logic [7:0]            r_resp_data;
    logic                  r_resp_id;

    logic                  w_accept;
    logic                  w_win_id;
    logic [1:0]            w_req_ready;
    logic [3:0]            w_a;
    logic [3:0]            w_b;
    logic [2:0]            w_op;
    logic                  w_exec_done;
    logic                  w_resp_fire;
    logic [7:0]            w_alu_res;

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE. On a tie the requester that did not win
    // last time gets the grant.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept    = 1'b0;
        w_win_id    = 1'b0;
        w_req_ready = 2'b00;
        if (r_state == ST_IDLE) begin
            if (req_valid == 2'b11) begin
                w_accept = 1'b1;
                w_win_id = ~r_last_gnt;
            end else if (req_valid[0]) begin
                w_accept = 1'b1;
                w_win_id = 1'b0;
            end else if (req_valid[1]) begin
                w_accept = 1'b1;
                w_win_id = 1'b1;
            end
            if (w_accept) begin
                w_req_ready[w_win_id] = 1'b1;
            end
        end
    end

    assign w_a  = w_win_id ? req1_a  : req0_a;
    assign w_b  = w_win_id ? req1_b  : req0_b;
    assign w_op = w_win_id ? req1_op : req0_op;

    assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == '0);
    assign w_resp_fire = r_resp_valid && resp_ready;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_exec_done) w_state_nxt = ST_DONE;
            ST_DONE: if (w_resp_fire) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Operand latch, latency counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_a          <= 4'h0;
            r_b          <= 4'h0;
            r_op         <= OP_ADD;
            r_id         <= 1'b0;
            r_last_gnt   <= 1'b1;   // requester 0 wins the first tie
            r_resp_valid <= 1'b0;
            r_resp_data  <= 8'h00;
            r_resp_id    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a        <= w_a;
                r_b        <= w_b;
                r_op       <= w_op;
                r_id       <= w_win_id;
                r_last_gnt <= w_win_id;
                r_cnt      <= (w_op == OP_MUL) ? c_MUL_LOAD : c_ALU_LOAD;
            end else if (r_state == ST_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_exec_done) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_alu_res;
                r_resp_id    <= r_id;
            end else if (w_resp_fire) begin
                // Data and id are left as-is; only valid drops.
                r_resp_valid <= 1'b0;
            end
        end
    end

    calc_alu u_calc_alu (
        .a   (r_a),
        .b   (r_b),
        .op  (r_op),
        .res (w_alu_res)
    );

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != ST_IDLE);

`ifdef CALC_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Grant statistics, wrap modulo 2^CNT_W
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else if (w_accept) begin
            if (w_win_id) r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
            else          r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule : calc_arbiter
`default_nettype wire

// File: tb/tb_calc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_arbiter
// Description : Directed self-checking bench for calc_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_id;
    logic       busy;
`ifdef CALC_ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
`endif

    int compared = 0;
    int mismatched = 0;

    calc_arbiter #(
        .ALU_CYCLES (1),
        .MUL_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef CALC_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from a single requester and observe the response.
    // Entered and left at posedge+1 with the DUT idle; resp_ready must be 1.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, output logic [1:0] rdy,
                          output int lat, output logic [7:0] data, output logic rid);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01;
        end
        #1;
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid = 2'b00;
        // Scramble operands after accept; the DUT must use its latched copy.
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data = resp_data;
        rid  = resp_id;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b00;
        resp_ready = 1'b1;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compared++;
        if ({resp_valid, resp_data, resp_id, busy, req_ready} !== 13'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b d=%h id=%b busy=%b rdy=%b, expected all zero",
                     resp_valid, resp_data, resp_id, busy, req_ready);
        end
`ifdef CALC_ARB_STATS_EN
        compared++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", gnt_cnt0, gnt_cnt1);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_ops;
        logic [1:0] rdy;
        int         lat;
        logic [7:0] d;
        logic       rid;
        // id, a, b, op, expected result, expected latency
        logic       v_id  [11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
        logic [3:0] v_a   [11] = '{9, 9, 3, 9, 9, 9, 9, 9, 15, 0, 15};
        logic [3:0] v_b   [11] = '{3, 3, 9, 2, 1, 3, 3, 3, 15, 15, 15};
        logic [2:0] v_op  [11] = '{3'b000, 3'b010, 3'b001, 3'b110, 3'b111, 3'b011,
                                   3'b100, 3'b101, 3'b010, 3'b001, 3'b000};
        logic [7:0] v_exp [11] = '{8'h0C, 8'h1B, 8'hFA, 8'h24, 8'h04, 8'h01,
                                   8'h0B, 8'h0A, 8'hE1, 8'hF1, 8'h1E};
        int         v_lat [11] = '{1, 3, 1, 1, 1, 1, 1, 1, 3, 1, 1};
        for (int i = 0; i < 11; i++) begin
            run_op(v_id[i], v_a[i], v_b[i], v_op[i], rdy, lat, d, rid);
            compared++;
            if (rdy !== (v_id[i] ? 2'b10 : 2'b01)) begin
                mismatched++;
                $display("FAIL op%0d_ready: got %b, expected %b", i, rdy, v_id[i] ? 2'b10 : 2'b01);
            end
            compared++;
            if (lat !== v_lat[i]) begin
                mismatched++;
                $display("FAIL op%0d_latency: got %0d, expected %0d", i, lat, v_lat[i]);
            end
            compared++;
            if (d !== v_exp[i] || rid !== v_id[i]) begin
                mismatched++;
                $display("FAIL op%0d_result: got %h id %b, expected %h id %b",
                         i, d, rid, v_exp[i], v_id[i]);
            end
            compared++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL op%0d_idle: got v=%b busy=%b, expected 0 0", i, resp_valid, busy);
            end
        end
    endtask

    task automatic test_round_robin;
        int t = 0;
        int last_t = 0;
        int g = 0;
        logic last_id = 1'b0;
        // Fresh reset so the first tie goes to requester 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_a = 1; req0_b = 1; req0_op = 3'b000;
        req1_a = 2; req1_b = 2; req1_op = 3'b000;
        resp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        while (g < 5 && t < 100) begin
            if (req_ready != 2'b00) begin
                compared++;
                if (req_ready !== ((g % 2) ? 2'b10 : 2'b01)) begin
                    mismatched++;
                    $display("FAIL rr_grant%0d: got %b, expected %b", g, req_ready,
                             (g % 2) ? 2'b10 : 2'b01);
                end
                if (g > 0) begin
                    compared++;
                    if (t - last_t !== 3) begin
                        mismatched++;
                        $display("FAIL rr_spacing%0d: got %0d clks, expected 3", g, t - last_t);
                    end
                end
                last_t = t;
                last_id = req_ready[1];
                g++;
            end
            if (resp_valid) begin
                compared++;
                if (resp_id !== last_id || resp_data !== (last_id ? 8'h04 : 8'h02)) begin
                    mismatched++;
                    $display("FAIL rr_resp: got %h id %b, expected %h id %b", resp_data, resp_id,
                             last_id ? 8'h04 : 8'h02, last_id);
                end
            end
            if (g < 5) begin
                @(posedge clk); #1;
                t++;
            end
        end
        compared++;
        if (g !== 5) begin
            mismatched++;
            $display("FAIL rr_timeout: got %0d grants, expected 5", g);
        end
        @(posedge clk); #1;   // last accept edge
        req_valid = 2'b00;
        t = 0;
        while (busy && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
`ifdef CALC_ARB_STATS_EN
        compared++;
        if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2) begin
            mismatched++;
            $display("FAIL stats_counts: got %0d/%0d, expected 3/2", gnt_cnt0, gnt_cnt1);
        end
`endif
    endtask

    task automatic test_backpressure;
        int t = 0;
        resp_ready = 1'b0;
        req0_a = 9; req0_b = 3; req0_op = 3'b101;
        req_valid = 2'b01;
        @(posedge clk); #1;   // accept
        req_valid = 2'b11;    // keep both requesting; nothing may be accepted
        while (!resp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (resp_valid !== 1'b1 || resp_data !== 8'h0A || resp_id !== 1'b0 ||
                req_ready !== 2'b00) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got v=%b d=%h id=%b rdy=%b, expected 1 0a 0 00",
                         i, resp_valid, resp_data, resp_id, req_ready);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        compared++;
        if (req_ready !== 2'b00) begin
            mismatched++;
            $display("FAIL bp_handshake_ready: got %b, expected 00", req_ready);
        end
        @(posedge clk); #1;
        compared++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_release: got v=%b busy=%b, expected 0 0", resp_valid, busy);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        t = 0;
        while (busy && t < 20) begin
            if (resp_valid) resp_ready = 1'b1;
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic test_reset_mid_exec;
        int seen = 0;
        req1_a = 9; req1_b = 3; req1_op = 3'b010;
        req_valid = 2'b10;
        @(posedge clk); #1;   // accept
        req_valid = 2'b00;
        @(posedge clk); #1;   // in EXEC
        rst = 1'b1;
        #1;
        compared++;
        if ({resp_valid, resp_data, resp_id, busy, req_ready} !== 13'd0) begin
            mismatched++;
            $display("FAIL midexec_reset: got v=%b d=%h id=%b busy=%b rdy=%b, expected all zero",
                     resp_valid, resp_data, resp_id, busy, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid || busy) seen++;
            @(posedge clk); #1;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL midexec_no_resp: got %0d active cycles, expected 0", seen);
        end
        req0_a = 1; req1_a = 1;
        req_valid = 2'b11;
        #1;
        compared++;
        if (req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL midexec_first_tie: got %b, expected 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_calc_arbiter
`default_nettype wire
